// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: per-stage register/control taps in, stall/flush/forward/status out.
// The pipeline side uses the master modport, hazard_ctrl uses the slave modport.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E;
  logic [4:0]       RdE, RdM, RdW;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             ResultSrcE, PCSrcE, MemAccessM, dmem_ready;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemAccessM, dmem_ready,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE,
    input  mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemAccessM, dmem_ready,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE,
    output mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward sequencing for the 5-stage core with a memory-wait FSM.
// Define HAZARD_FORWARDING_EN for bypass forwarding; otherwise every RAW dependency stalls.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned WAIT_W      = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  localparam logic [WAIT_W:0] TIMEOUT_L = (WAIT_W+1)'(MEM_TIMEOUT);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic freeze_c;
  logic data_hz_c;
  logic stall_fd_c;
  logic flush_d_c;
  logic flush_e_c;

  // A write-enabled, nonzero destination matching a source register (x0 never hazards).
  function automatic logic dep(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (dep(hz.RegWriteM, hz.RdM, rs))      return 2'b10;
    else if (dep(hz.RegWriteW, hz.RdW, rs)) return 2'b01;
    else                                    return 2'b00;
  endfunction

`ifdef HAZARD_FORWARDING_EN
  assign data_hz_c = hz.ResultSrcE &&
                     (dep(hz.RegWriteE, hz.RdE, hz.Rs1D) || dep(hz.RegWriteE, hz.RdE, hz.Rs2D));
  assign hz.ForwardAE = fwd_sel(hz.Rs1E);
  assign hz.ForwardBE = fwd_sel(hz.Rs2E);
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{hz.ResultSrcE, hz.Rs1E, hz.Rs2E, fwd_sel(5'd0)};
  assign data_hz_c = dep(hz.RegWriteE, hz.RdE, hz.Rs1D) || dep(hz.RegWriteE, hz.RdE, hz.Rs2D) ||
                     dep(hz.RegWriteM, hz.RdM, hz.Rs1D) || dep(hz.RegWriteM, hz.RdM, hz.Rs2D) ||
                     dep(hz.RegWriteW, hz.RdW, hz.Rs1D) || dep(hz.RegWriteW, hz.RdW, hz.Rs2D);
  assign hz.ForwardAE = 2'b00;
  assign hz.ForwardBE = 2'b00;
`endif

  // Freeze dominates; a taken branch kills the decode instruction so its data hazard is moot.
  always_comb begin
    freeze_c   = (state_q == MEM_WAIT) || (hz.MemAccessM && !hz.dmem_ready);
    stall_fd_c = freeze_c || (!hz.PCSrcE && data_hz_c);
    flush_d_c  = !freeze_c && hz.PCSrcE;
    flush_e_c  = !freeze_c && (hz.PCSrcE || data_hz_c);
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    case (state_q)
      RUN: begin
        if (hz.MemAccessM && !hz.dmem_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (hz.dmem_ready) begin
          state_d = RUN;
        end else if ((WAIT_W+1)'(wait_cnt_q) + (WAIT_W+1)'(1) == TIMEOUT_L) begin
          state_d   = RUN;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    if (stall_fd_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_d_c && (flush_cnt_q != '1))  flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.StallF    = stall_fd_c;
  assign hz.StallD    = stall_fd_c;
  assign hz.StallE    = freeze_c;
  assign hz.StallM    = freeze_c;
  assign hz.FlushD    = flush_d_c;
  assign hz.FlushE    = flush_e_c;
  assign hz.mem_err   = mem_err_q;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios followed by random traffic,
// each cycle's expected outputs queued by the stimulus and checked by a separate monitor.
module tb_hazard_ctrl;
  localparam int unsigned TO = 4;
  localparam int unsigned WW = 8;
  localparam int unsigned CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hif ();
  hazard_ctrl #(.MEM_TIMEOUT(TO), .WAIT_W(WW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .hz(hif)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwe, rwm, rww, lde, br, mem, rdy;
  } stim_t;

  typedef struct packed {
    logic [3:0]    stall;   // F, D, E, M
    logic [1:0]    flush;   // D, E
    logic [1:0]    fa, fb;
    logic          err;
    logic [CW-1:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: memory-wait episode bookkeeping and activity totals.
  bit    m_wait;
  int    m_waited;
  bit    m_err;
  int    m_sc, m_fc;
  stim_t cur;
  exp_t  cur_e;

  function automatic void model_reset();
    m_wait = 0; m_waited = 0; m_err = 0; m_sc = 0; m_fc = 0;
  endfunction

  function automatic logic [1:0] exp_fwd(input stim_t s, input logic [4:0] rs);
`ifdef HAZARD_FORWARDING_EN
    if (s.rwm && s.rdm != 0 && s.rdm == rs) return 2'd2;
    if (s.rww && s.rdw != 0 && s.rdw == rs) return 2'd1;
`endif
    return 2'd0;
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t       e;
    bit         frozen, hazard, kill;
    logic [4:0] rd[3];
    logic       we[3];
    frozen = m_wait || (s.mem && !s.rdy);
    hazard = 0;
`ifdef HAZARD_FORWARDING_EN
    hazard = s.lde && s.rwe && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
`else
    rd = '{s.rde, s.rdm, s.rdw};
    we = '{s.rwe, s.rwm, s.rww};
    for (int i = 0; i < 3; i++)
      if (we[i] && rd[i] != 0 && (rd[i] == s.rs1d || rd[i] == s.rs2d)) hazard = 1;
`endif
    kill = !frozen && s.br;
    e.stall = {frozen || (!kill && hazard), frozen || (!kill && hazard), frozen, frozen};
    e.flush = {kill, !frozen && (s.br || hazard)};
    e.fa    = exp_fwd(s, s.rs1e);
    e.fb    = exp_fwd(s, s.rs2e);
    e.err   = m_err;
    e.sc    = CW'(m_sc);
    e.fc    = CW'(m_fc);
    return e;
  endfunction

  function automatic void model_advance(input stim_t s, input exp_t e);
    if (s.rst) begin
      model_reset();
      return;
    end
    if (m_wait) begin
      if (s.rdy) m_wait = 0;
      else if (m_waited + 1 == TO) begin m_wait = 0; m_err = 1; end
      else m_waited++;
    end else if (s.mem && !s.rdy) begin
      m_wait = 1; m_waited = 0;
    end
    if (e.stall[2] && m_sc < CMAX) m_sc++;
    if (e.flush[1] && m_fc < CMAX) m_fc++;
  endfunction

  task automatic drive(input stim_t s);
    reset          = s.rst;
    hif.Rs1D       = s.rs1d; hif.Rs2D = s.rs2d;
    hif.Rs1E       = s.rs1e; hif.Rs2E = s.rs2e;
    hif.RdE        = s.rde;  hif.RdM  = s.rdm;  hif.RdW = s.rdw;
    hif.RegWriteE  = s.rwe;  hif.RegWriteM = s.rwm; hif.RegWriteW = s.rww;
    hif.ResultSrcE = s.lde;  hif.PCSrcE = s.br;
    hif.MemAccessM = s.mem;  hif.dmem_ready = s.rdy;
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    model_advance(cur, cur_e);
    #1;
    drive(s);
    if (s.rst) model_reset();
    cur   = s;
    cur_e = predict(s);
    q.push_back(cur_e);
  endtask

  // Monitor: every cycle presents a full set of outputs; compare away from the active edge.
  initial begin
    exp_t e;
    logic [9:0]      act_ctrl;
    logic [2*CW:0]   act_stat;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act_ctrl = {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD, hif.FlushE,
                    hif.ForwardAE, hif.ForwardBE};
        act_stat = {hif.mem_err, hif.stall_cnt, hif.flush_cnt};
        checks++;
        if (act_ctrl !== {e.stall, e.flush, e.fa, e.fb}) begin
          errors++;
          $display("FAIL ctrl @%0t: got stall=%b flush=%b fa=%b fb=%b, expected stall=%b flush=%b fa=%b fb=%b",
                   $time, act_ctrl[9:6], act_ctrl[5:4], act_ctrl[3:2], act_ctrl[1:0],
                   e.stall, e.flush, e.fa, e.fb);
        end
        checks++;
        if (act_stat !== {e.err, e.sc, e.fc}) begin
          errors++;
          $display("FAIL status @%0t: got err=%b stall_cnt=%0d flush_cnt=%0d, expected err=%b stall_cnt=%0d flush_cnt=%0d",
                   $time, act_stat[2*CW], act_stat[2*CW-1:CW], act_stat[CW-1:0], e.err, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s0, s;
    s0 = '0;
    cur = s0; cur.rst = 1'b1;
    model_reset();
    cur_e = predict(cur);
    drive(cur);

    // Reset and idle
    s = s0; s.rst = 1; step(s); step(s);
    repeat (2) step(s0);

    // Load-use then forward from memory stage
    s = s0; s.lde = 1; s.rwe = 1; s.rde = 5; s.rs1d = 5; step(s);
    s = s0; s.rwm = 1; s.rdm = 5; s.rs1e = 5; step(s);

    // Double forward: memory over writeback, then writeback only, then x0
    s = s0; s.rwm = 1; s.rww = 1; s.rdm = 7; s.rdw = 7; s.rs2e = 7; step(s);
    s.rwm = 0; step(s);
    s.rdm = 0; s.rdw = 0; step(s);

    // Taken branch coincident with load-use
    s = s0; s.lde = 1; s.rwe = 1; s.rde = 5; s.rs2d = 5; s.br = 1; step(s);
    step(s0);

    // Memory wait of 3 cycles, then release
    s = s0; s.mem = 1; repeat (3) step(s);
    s.rdy = 1; step(s);
    repeat (2) step(s0);

    // Timeout with ready held low
    s = s0; s.mem = 1; repeat (7) step(s);
    repeat (2) step(s0);

    // Reset in the middle of a wait episode
    s = s0; s.mem = 1; repeat (2) step(s);
    s.rst = 1; step(s);
    repeat (2) step(s0);

    // RAW on memory-stage destination (stalls only without forwarding)
    s = s0; s.rwm = 1; s.rdm = 3; s.rs2d = 3; s.rs2e = 3; step(s);

    // Counter saturation
    s = s0; s.lde = 1; s.rwe = 1; s.rde = 9; s.rs1d = 9; repeat (20) step(s);
    s = s0; s.br = 1; repeat (20) step(s);
    s = s0; s.rst = 1; step(s);

    // Random traffic on a small register set so matches and x0 are frequent
    for (int n = 0; n < 3000; n++) begin
      s.rst  = ($urandom_range(0, 299) == 0);
      s.rs1d = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
      s.rs1e = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
      s.rde  = 5'($urandom_range(0, 3)); s.rdm  = 5'($urandom_range(0, 3));
      s.rdw  = 5'($urandom_range(0, 3));
      s.rwe  = 1'($urandom_range(0, 1)); s.rwm = 1'($urandom_range(0, 1));
      s.rww  = 1'($urandom_range(0, 1)); s.lde = 1'($urandom_range(0, 1));
      s.br   = ($urandom_range(0, 5) == 0);
      s.mem  = ($urandom_range(0, 3) == 0);
      s.rdy  = ($urandom_range(0, 2) == 0);
      step(s);
    end
    step(s0);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
